cursor_controller: RTL

//  Sequences the chessboard crosshair cursor: turns USB keycodes into board moves and drives the

---
 rtl/cursor_controller.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cursor_controller.sv
// rtl/cursor_controller.sv - chessboard cursor sequencer with pick-source/pick-destination move FSM (optional CURSOR_WRAP_EN)
module cursor_controller #(
    parameter int unsigned BOARD_X0     = 80,
    parameter int unsigned BOARD_Y0     = 0,
    parameter int unsigned SQ_SIZE      = 60,
    parameter int unsigned CURSOR_SIZE  = 10,
    parameter int unsigned REPEAT_DELAY = 20,
    parameter int unsigned REPEAT_RATE  = 6
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic [2:0] cur_col,
    output logic [2:0] cur_row,
    output logic       src_active,
    output logic [5:0] src_sq,
    output logic       mv_valid,
    input  logic       mv_ready,
    output logic [5:0] mv_from,
    output logic [5:0] mv_to
);

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_ESC   = 8'h29;

    localparam logic [2:0] RESET_COL = 3'd4;
    localparam logic [2:0] RESET_ROW = 3'd6;

    typedef enum logic [1:0] {
        PICK_SRC = 2'd0,
        PICK_DST = 2'd1,
        ISSUE    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] last_key;
    logic [7:0] rep_cnt;
    logic [2:0] col_nxt;
    logic [2:0] row_nxt;
    logic       is_move;
    logic       key_new;
    logic       step_now;
    logic       space_press;
    logic       esc_press;
    logic [5:0] cur_sq;

    // Pixel centre of a square along one axis; truncated to the 10-bit screen coordinate.
    function automatic logic [9:0] pix(input int unsigned base, input logic [2:0] idx);
        return 10'(base + 32'(idx) * SQ_SIZE + SQ_SIZE / 2);
    endfunction

    // One step towards index 7; at the edge either wrap to 0 or stay put.
    function automatic logic [2:0] step_up(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
        return v + 3'd1;
`else
        return (v == 3'd7) ? v : v + 3'd1;
`endif
    endfunction

    // One step towards index 0; at the edge either wrap to 7 or stay put.
    function automatic logic [2:0] step_dn(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
        return v - 3'd1;
`else
        return (v == 3'd0) ? v : v - 3'd1;
`endif
    endfunction

    assign cur_sq    = {cur_row, cur_col};
    assign Ball_size = 10'(CURSOR_SIZE);

    // Key decode: press edges come from comparing against the keycode seen on the previous tick.
    always_comb begin
        is_move     = (keycode == KEY_W) || (keycode == KEY_S) ||
                      (keycode == KEY_A) || (keycode == KEY_D);
        key_new     = (keycode != last_key);
        step_now    = frame_tick && is_move && (state != ISSUE) &&
                      (key_new || (rep_cnt == 8'd1));
        space_press = frame_tick && (keycode == KEY_SPACE) && (last_key != KEY_SPACE);
        esc_press   = frame_tick && (keycode == KEY_ESC) && (last_key != KEY_ESC);
    end

    // Next cursor position for a step in the held key's direction.
    always_comb begin
        col_nxt = cur_col;
        row_nxt = cur_row;
        if (step_now) begin
            case (keycode)
                KEY_W:   row_nxt = step_dn(cur_row);
                KEY_S:   row_nxt = step_up(cur_row);
                KEY_A:   col_nxt = step_dn(cur_col);
                KEY_D:   col_nxt = step_up(cur_col);
                default: ;
            endcase
        end
    end

    // Key history and auto-repeat countdown, advanced once per frame.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            last_key <= 8'h00;
            rep_cnt  <= 8'h00;
        end else if (frame_tick) begin
            last_key <= keycode;
            if (is_move) begin
                if (key_new)
                    rep_cnt <= 8'(REPEAT_DELAY);
                else if (rep_cnt == 8'd1)
                    rep_cnt <= 8'(REPEAT_RATE);
                else if (rep_cnt != 8'd0)
                    rep_cnt <= rep_cnt - 8'd1;
            end
        end
    end

    // Cursor square and its registered pixel centre, which trails the square by one Clk.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cur_col <= RESET_COL;
            cur_row <= RESET_ROW;
            BallX   <= pix(BOARD_X0, RESET_COL);
            BallY   <= pix(BOARD_Y0, RESET_ROW);
        end else begin
            cur_col <= col_nxt;
            cur_row <= row_nxt;
            BallX   <= pix(BOARD_X0, cur_col);
            BallY   <= pix(BOARD_Y0, cur_row);
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            state <= PICK_SRC;
        else
            state <= state_nxt;
    end

    // FSM next state: selection keys act only outside ISSUE, which waits solely for the handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            PICK_SRC: begin
                if (space_press)
                    state_nxt = PICK_DST;
            end
            PICK_DST: begin
                if (space_press)
                    state_nxt = (cur_sq == src_sq) ? PICK_SRC : ISSUE;
                else if (esc_press)
                    state_nxt = PICK_SRC;
            end
            ISSUE: begin
                if (mv_ready)
                    state_nxt = PICK_SRC;
            end
            default: state_nxt = PICK_SRC;
        endcase
    end

    // Move registers: source captured on selection, move captured on leaving PICK_DST for ISSUE.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            src_sq  <= 6'd0;
            mv_from <= 6'd0;
            mv_to   <= 6'd0;
        end else begin
            if (state == PICK_SRC && space_press)
                src_sq <= cur_sq;
            if (state == PICK_DST && space_press && cur_sq != src_sq) begin
                mv_from <= src_sq;
                mv_to   <= cur_sq;
            end
        end
    end

    // FSM outputs: source stays highlighted until the move is accepted or the pick is dropped.
    always_comb begin
        mv_valid   = (state == ISSUE);
        src_active = (state != PICK_SRC);
    end

endmodule
